// File: rtl/onewire_pkg.sv
// Shared definitions for the one-wire command/response link: widths, the
// ping command and its acknowledge, controller states and attempt-failure causes.
package onewire_pkg;

  localparam int DATA_W = 56;
  localparam logic [DATA_W-1:0] CMD_PING = 56'hAA55AA55AA55AA;
  localparam logic [DATA_W-1:0] RSP_ACK  = 56'hFFFFFFFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_RX_ERROR = 2'd2
  } cause_e;

  // Attempts used = retries + 1, saturating at the 2-bit maximum.
  function automatic logic [1:0] sat_attempts(input int unsigned retries);
    if (retries >= 32'd2) begin
      return 2'd3;
    end else begin
      return 2'(retries + 32'd1);
    end
  endfunction

endpackage

// File: rtl/onewire_master_ctrl_if.sv
// Host, command-lane transmitter and response-lane receiver signals of the
// initiator-side controller, bundled for a single module port.
interface onewire_master_ctrl_if import onewire_pkg::*; ();

  logic              i_req;
  logic [DATA_W-1:0] i_cmd;
  logic              o_ready;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_match;
  logic              o_timeout;
  logic              o_rx_error;
  logic [1:0]        o_attempts;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_start;
  logic              i_tx_busy;
  logic              i_tx_done;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_error;

  modport master (
    input  i_req, i_cmd, i_tx_busy, i_tx_done, i_rx_data, i_rx_error,
    output o_ready, o_rsp_valid, o_rsp_data, o_rsp_match, o_timeout,
           o_rx_error, o_attempts, o_tx_data, o_tx_start
  );

  modport slave (
    output i_req, i_cmd, i_tx_busy, i_tx_done, i_rx_data, i_rx_error,
    input  o_ready, o_rsp_valid, o_rsp_data, o_rsp_match, o_timeout,
           o_rx_error, o_attempts, o_tx_data, o_tx_start
  );

endinterface

// File: rtl/onewire_timeout_ctr.sv
// Per-attempt watchdog: counts enabled cycles and strobes expire on the cycle
// the count equals TIMEOUT_CYCLES-1, then restarts from zero.
module onewire_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_r;

  assign expire = enable && (count_r == LAST);

  // Cycle counter; clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r <= {TW{1'b0}};
      end else begin
        count_r <= count_r + TW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/onewire_master_ctrl.sv
// Initiator-side controller: launches one host command on the transmitter and
// waits for a changed reply on the level-only receiver, with timeout and retries.
module onewire_master_ctrl import onewire_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  onewire_master_ctrl_if.master bus
);

  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  state_e            state_r;
  logic [DATA_W-1:0] cmd_q_r;
  logic [DATA_W-1:0] rx_base_r;
  logic [RW-1:0]     retry_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              match_r;
  logic              timeout_r;
  logic              rx_err_r;
  logic [1:0]        attempts_r;
  logic              tx_start_r;

  logic   expire_s;
  logic   fail_s;
  logic   rsp_seen_s;
  cause_e cause_s;
  logic   tmr_clear_s;
  logic   tmr_enable_s;

  assign tmr_clear_s  = (state_r == ST_LAUNCH) || ((state_r == ST_SEND) && bus.i_tx_done);
  assign tmr_enable_s = (state_r == ST_SEND) || (state_r == ST_WAIT_RSP);

  onewire_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear_s),
    .enable (tmr_enable_s),
    .expire (expire_s)
  );

  // Attempt outcome this cycle; rx error beats a data change, which beats expiry.
  always_comb begin
    fail_s     = 1'b0;
    rsp_seen_s = 1'b0;
    cause_s    = CAUSE_NONE;
    case (state_r)
      ST_SEND: begin
        if (!bus.i_tx_done && expire_s) begin
          fail_s  = 1'b1;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          fail_s = 1'b0;
        end
      end
      ST_WAIT_RSP: begin
        if (bus.i_rx_error) begin
          fail_s  = 1'b1;
          cause_s = CAUSE_RX_ERROR;
        end else if (bus.i_rx_data != rx_base_r) begin
          rsp_seen_s = 1'b1;
        end else if (expire_s) begin
          fail_s  = 1'b1;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          fail_s = 1'b0;
        end
      end
      default: begin
        fail_s = 1'b0;
      end
    endcase
  end

  // Request sequencing FSM with all host- and transmitter-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_q_r     <= {DATA_W{1'b0}};
      rx_base_r   <= {DATA_W{1'b0}};
      retry_r     <= {RW{1'b0}};
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      match_r     <= 1'b0;
      timeout_r   <= 1'b0;
      rx_err_r    <= 1'b0;
      attempts_r  <= 2'd0;
      tx_start_r  <= 1'b0;
    end else begin
      tx_start_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      if (fail_s) begin
        if (retry_r < RW'(MAX_RETRIES)) begin
          retry_r   <= retry_r + RW'(1);
          rx_base_r <= bus.i_rx_data;
          state_r   <= ST_LAUNCH;
        end else begin
          rsp_valid_r <= 1'b1;
          match_r     <= 1'b0;
          timeout_r   <= (cause_s == CAUSE_TIMEOUT);
          rx_err_r    <= (cause_s == CAUSE_RX_ERROR);
          attempts_r  <= sat_attempts(32'(retry_r));
          state_r     <= ST_DONE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.i_req && ready_r) begin
              cmd_q_r   <= bus.i_cmd;
              rx_base_r <= bus.i_rx_data;
              retry_r   <= {RW{1'b0}};
              timeout_r <= 1'b0;
              rx_err_r  <= 1'b0;
              match_r   <= 1'b0;
              ready_r   <= 1'b0;
              state_r   <= ST_LAUNCH;
            end else begin
              ready_r <= 1'b1;
            end
          end
          ST_LAUNCH: begin
            if (!bus.i_tx_busy) begin
              tx_start_r <= 1'b1;
              state_r    <= ST_SEND;
            end else begin
              state_r <= ST_LAUNCH;
            end
          end
          ST_SEND: begin
            if (bus.i_tx_done) begin
              state_r <= ST_WAIT_RSP;
            end else begin
              state_r <= ST_SEND;
            end
          end
          ST_WAIT_RSP: begin
            if (rsp_seen_s) begin
              rsp_data_r  <= bus.i_rx_data;
              match_r     <= (cmd_q_r == CMD_PING) ? (bus.i_rx_data == RSP_ACK) : 1'b1;
              attempts_r  <= sat_attempts(32'(retry_r));
              rsp_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_WAIT_RSP;
            end
          end
          ST_DONE: begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
          default: begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_data  = rsp_data_r;
  assign bus.o_rsp_match = match_r;
  assign bus.o_timeout   = timeout_r;
  assign bus.o_rx_error  = rx_err_r;
  assign bus.o_attempts  = attempts_r;
  assign bus.o_tx_data   = cmd_q_r;
  assign bus.o_tx_start  = tx_start_r;

endmodule

// File: tb/tb_onewire_master_ctrl.sv
// Scoreboard bench for onewire_master_ctrl: directed requests push expected
// results; a negedge monitor pops and compares on every o_rsp_valid.
module tb_onewire_master_ctrl;
  import onewire_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onewire_master_ctrl_if bus();

  onewire_master_ctrl #(.TIMEOUT_CYCLES(64), .MAX_RETRIES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              match;
    logic              timeout;
    logic              rx_error;
    logic [1:0]        attempts;
  } exp_t;

  exp_t              exp_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                start_cnt = 0;
  int                valid_cnt = 0;
  logic [DATA_W-1:0] exp_cmd;
  logic              ext_busy;
  logic              tx_busy_m;
  logic              tx_done_m;
  int                tx_cnt;
  int                v0;
  int                s0;

  assign bus.i_tx_busy = ext_busy | tx_busy_m;
  assign bus.i_tx_done = tx_done_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic m, input logic t,
                      input logic e, input logic [1:0] a);
    exp_t x;
    x.data = d; x.match = m; x.timeout = t; x.rx_error = e; x.attempts = a;
    exp_q.push_back(x);
  endtask

  task automatic do_req(input logic [DATA_W-1:0] cmd);
    bit rdy = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      if (bus.o_ready) rdy = 1'b1;
      else tick();
    end
    chk("ready_before_req", 64'(rdy), 64'd1);
    exp_cmd   = cmd;
    bus.i_cmd = cmd;
    bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = tx_done_m;
    end
    chk("tx_done_wait", 64'(seen), 64'd1);
  endtask

  task automatic wait_valid(input int base, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      seen = (valid_cnt > base);
    end
    chk("rsp_valid_wait", 64'(seen), 64'd1);
  endtask

  // Transmitter model: 20 busy cycles after each start, then a one-cycle done.
  initial begin
    tx_busy_m = 1'b0;
    tx_done_m = 1'b0;
    tx_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_m = 1'b0;
      if (bus.o_tx_start && !tx_busy_m) begin
        tx_busy_m = 1'b1;
        tx_cnt    = 20;
      end else if (tx_busy_m) begin
        if (tx_cnt <= 1) begin
          tx_busy_m = 1'b0;
          tx_done_m = 1'b1;
        end else begin
          tx_cnt--;
        end
      end
    end
  end

  // Monitor: count start pulses and score every result strobe.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        start_cnt++;
        chk("tx_data_at_start", 64'(bus.o_tx_data), 64'(exp_cmd));
      end
      if (bus.o_rsp_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 64'd1, 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("rsp_data",  64'(bus.o_rsp_data),  64'(x.data));
          chk("rsp_match", 64'(bus.o_rsp_match), 64'(x.match));
          chk("timeout",   64'(bus.o_timeout),   64'(x.timeout));
          chk("rx_error",  64'(bus.o_rx_error),  64'(x.rx_error));
          chk("attempts",  64'(bus.o_attempts),  64'(x.attempts));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ext_busy = 1'b0;
    bus.i_req = 1'b0;
    bus.i_cmd = {DATA_W{1'b0}};
    bus.i_rx_data = {DATA_W{1'b0}};
    bus.i_rx_error = 1'b0;
    exp_cmd = {DATA_W{1'b0}};
    repeat (3) tick();
    chk("reset_ready",     64'(bus.o_ready),     64'd1);
    chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("reset_tx_start",  64'(bus.o_tx_start),  64'd0);
    chk("reset_attempts",  64'(bus.o_attempts),  64'd0);
    chk("reset_rsp_data",  64'(bus.o_rsp_data),  64'd0);
    chk("reset_tx_data",   64'(bus.o_tx_data),   64'd0);
    chk("reset_timeout",   64'(bus.o_timeout),   64'd0);
    reset = 1'b0;
    tick();

    // Ping with correct acknowledge
    v0 = valid_cnt; s0 = start_cnt;
    push(RSP_ACK, 1'b1, 1'b0, 1'b0, 2'd1);
    do_req(CMD_PING);
    wait_done();
    repeat (10) tick();
    bus.i_rx_data = RSP_ACK;
    wait_valid(v0, 60);
    chk("t1_ready_after_valid", 64'(bus.o_ready), 64'd1);
    chk("t1_starts", 64'(start_cnt - s0), 64'd1);

    // Ping with wrong reply
    v0 = valid_cnt; s0 = start_cnt;
    push(56'h00000000001234, 1'b0, 1'b0, 1'b0, 2'd1);
    do_req(CMD_PING);
    wait_done();
    repeat (10) tick();
    bus.i_rx_data = 56'h00000000001234;
    wait_valid(v0, 60);
    chk("t2_starts", 64'(start_cnt - s0), 64'd1);

    // Silent responder: all three attempts time out, reply register held
    v0 = valid_cnt; s0 = start_cnt;
    push(56'h00000000001234, 1'b0, 1'b1, 1'b0, 2'd3);
    do_req(56'h0000000000ABCD);
    wait_valid(v0, 500);
    chk("t3_starts", 64'(start_cnt - s0), 64'd3);

    // Receiver error on attempt 1, good reply on attempt 2
    v0 = valid_cnt; s0 = start_cnt;
    push(RSP_ACK, 1'b1, 1'b0, 1'b0, 2'd2);
    do_req(CMD_PING);
    wait_done();
    repeat (5) tick();
    bus.i_rx_error = 1'b1;
    tick();
    bus.i_rx_error = 1'b0;
    wait_done();
    repeat (10) tick();
    bus.i_rx_data = RSP_ACK;
    wait_valid(v0, 100);
    chk("t4_starts", 64'(start_cnt - s0), 64'd2);

    // Busy gating, plus a request during WAIT_RSP that must be ignored
    v0 = valid_cnt; s0 = start_cnt;
    ext_busy = 1'b1;
    push(56'h0BADC0DE000001, 1'b1, 1'b0, 1'b0, 2'd1);
    do_req(56'h123456789ABCDE);
    repeat (30) tick();
    chk("t5_no_start_while_busy", 64'(start_cnt - s0), 64'd0);
    ext_busy = 1'b0;
    wait_done();
    repeat (3) tick();
    bus.i_cmd = 56'h00000000000077;
    bus.i_req = 1'b1;
    repeat (2) tick();
    bus.i_req = 1'b0;
    repeat (5) tick();
    bus.i_rx_data = 56'h0BADC0DE000001;
    wait_valid(v0, 60);
    repeat (20) tick();
    chk("t5_one_valid", 64'(valid_cnt - v0), 64'd1);
    chk("t5_starts", 64'(start_cnt - s0), 64'd1);
    chk("t5_ready_idle", 64'(bus.o_ready), 64'd1);

    // Reset while waiting for the reply
    v0 = valid_cnt;
    do_req(56'h00000000C0FFEE);
    wait_done();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("t6_ready_after_reset", 64'(bus.o_ready), 64'd1);
    chk("t6_tx_start_after_reset", 64'(bus.o_tx_start), 64'd0);
    chk("t6_valid_after_reset", 64'(bus.o_rsp_valid), 64'd0);
    reset = 1'b0;
    bus.i_rx_data = 56'h0000000000BEEF;
    repeat (100) tick();
    chk("t6_no_valid", 64'(valid_cnt - v0), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onewire_master_ctrl.md
Name: onewire_master_ctrl

Overview:
Initiator-side controller for the one-wire command/response link. It accepts a 56-bit command from the host and launches it through a command-lane transmitter (onewire_tx on bus1). It then waits for the responder's reply on the response-lane receiver (onewire_rx on bus2), with a timeout and bounded retries. It sits beside the onewire_tx/onewire_rx pair in the master top and reports one result per request.

Parameters:
DATA_W, 56, command/response width
TIMEOUT_CYCLES, 100000, max clk cycles in SEND or WAIT_RSP per attempt
MAX_RETRIES, 2, extra attempts after the first (total attempts = MAX_RETRIES+1)
CMD_PING, 56'hAA55AA55AA55AA, command with a known reply
RSP_ACK, 56'hFFFFFFFFFFFFFF, expected reply to CMD_PING

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high
i_req  in  1  host request; accepted when i_req & o_ready
i_cmd  in  DATA_W  command, sampled on accept
o_ready  out  1  high only in IDLE
o_rsp_valid  out  1  one-cycle result strobe
o_rsp_data  out  DATA_W  captured reply; held until next accept
o_rsp_match  out  1  valid with o_rsp_valid
o_timeout  out  1  valid with o_rsp_valid; all attempts expired
o_rx_error  out  1  valid with o_rsp_valid; last attempt ended on i_rx_error
o_attempts  out  2  attempts used, valid with o_rsp_valid
o_tx_data  out  DATA_W  to onewire_tx i_tx_data
o_tx_start  out  1  to onewire_tx i_tx_start, single-cycle pulse
i_tx_busy  in  1  from onewire_tx o_tx_busy
i_tx_done  in  1  from onewire_tx o_tx_done
i_rx_data  in  DATA_W  from onewire_rx o_command (level, no strobe)
i_rx_error  in  1  from onewire_rx o_error

Behaviour:
- Reset (sync): state IDLE; all outputs 0 except o_ready=1; internal cmd_q, rx_base, timer, retry_cnt cleared.
- Reset mid-operation: next edge returns to IDLE and o_tx_start=0. No o_rsp_valid is issued for the aborted request.
- States: IDLE, LAUNCH, SEND, WAIT_RSP, DONE. All outputs are registered.
- IDLE: on i_req & o_ready, latch cmd_q=i_cmd, snapshot rx_base=i_rx_data, retry_cnt=0, clear o_timeout/o_rx_error/o_rsp_match, then go to LAUNCH. i_req while not ready is ignored, with no queueing.
- LAUNCH: o_tx_data=cmd_q. Wait while i_tx_busy=1. On the first cycle with i_tx_busy=0, assert o_tx_start for exactly 1 cycle, clear timer, go to SEND.
- SEND: timer++. On i_tx_done, clear timer and go to WAIT_RSP. If the timer reaches TIMEOUT_CYCLES-1, take the attempt-failed path with timeout cause.
- WAIT_RSP: timer++. Priority within one cycle, highest first:
  - i_rx_error: attempt failed, error cause.
  - i_rx_data != rx_base: capture o_rsp_data=i_rx_data, go to DONE with success.
  - timer == TIMEOUT_CYCLES-1: attempt failed, timeout cause.
- Data change and timeout on the same cycle: data wins.
- Attempt-failed path:
  - If retry_cnt < MAX_RETRIES: retry_cnt++, rx_base=i_rx_data, go to LAUNCH.
  - Otherwise go to DONE, setting o_timeout=1 or o_rx_error=1 per the last cause; o_rsp_data keeps its previous value.
- DONE: o_rsp_valid=1 for one cycle; o_attempts=retry_cnt+1 saturating at 3; go to IDLE next cycle, so o_ready is high again in the cycle after o_rsp_valid.
- o_rsp_match:
  - Success with cmd_q==CMD_PING: 1 only if the reply equals RSP_ACK.
  - Success with any other command: 1.
  - Failure: 0.
- Timer width: $clog2(TIMEOUT_CYCLES); no wrap (compare-equal then restart). retry_cnt width: $clog2(MAX_RETRIES+1), minimum 1.
- Latency, best case: accept → o_tx_start is 1 cycle; i_tx_done → response detect is ≥1 cycle; detect → o_rsp_valid is 1 cycle.
- Reply identical to rx_base (same value as the previous reply) is not detectable and ends in timeout. This is a documented limitation of the level-only receiver.

Decomposition:
- Shared package onewire_pkg holds:
  - DATA_W, CMD_PING, RSP_ACK constants (also used by the responder top);
  - the state enum/localparams;
  - the result-cause encoding.
- One natural sub-module: onewire_timeout_ctr (clear, enable, expire strobe at TIMEOUT_CYCLES-1), instanced once.
- onewire_tx/onewire_rx are instanced at the master top level, not inside this block.

Test Plan:
- Bench TIMEOUT_CYCLES=64 throughout.
- Ping success: i_cmd=56'hAA55AA55AA55AA, tx model done after 20 cycles, rx changes 0→56'hFFFFFFFFFFFFFF 10 cycles later → one o_tx_start pulse, o_rsp_valid once, o_rsp_data=FFFFFFFFFFFFFF, o_rsp_match=1, o_attempts=1.
- Ping wrong reply: rx changes to 56'h00000000001234 → o_rsp_valid, o_rsp_match=0, o_timeout=0.
- Silent responder (MAX_RETRIES=2): rx never changes → exactly 3 o_tx_start pulses, o_timeout=1, o_attempts=3, o_rsp_valid one cycle after the third expiry.
- Error then success: i_rx_error on attempt 1, valid reply on attempt 2 → 2 start pulses, o_rx_error=0, o_rsp_match=1, o_attempts=2.
- Busy gating and req-while-busy: i_tx_busy=1 for 30 cycles at accept → o_tx_start delayed until busy falls. Second i_req during WAIT_RSP is ignored, giving exactly one o_rsp_valid.
- Reset in WAIT_RSP: assert reset 1 cycle → o_ready=1, o_tx_start=0 next cycle, and no o_rsp_valid afterwards.
